pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (MEM/WB style): a DEPTH-deep chain of pipeline registers carrying a data word plus a control vector.
- Per-stage valid bits; valid/ready handshake on both ends replaces the bare stall.
- Per-stage flush mask; optional bubble collapsing.
- Registered occupancy count.
- Used between CPU pipeline stages and as a short elastic buffer on memory return paths.

Parameters:
DATA_W, 32, width of the data payload (e.g. WBData/MemData).
CTRL_W, 8, width of the control payload (RegWrite, MemRead, Rd, byte enables...); cleared on flush.
DEPTH, 2, number of register stages, legal range 1..8.
COLLAPSE, 1, 1 = per-stage advance (bubbles squeezed out); 0 = lockstep shift (classic pipeline).
FLUSH_DATA, 0, 1 = flush also zeroes data of the killed stage; 0 = data retained (don't-care).

Ports:
clk  in  1  clock; all state updates on the falling edge of clk.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream item present.
in_ready  out  1  chain accepts the item at this edge (combinational).
in_data  in  DATA_W  upstream data.
in_ctrl  in  CTRL_W  upstream control.
flush_mask  in  DEPTH  bit i kills stage i at this edge (bit 0 = input-side stage).
out_valid  out  1  = valid[DEPTH-1] (registered).
out_ready  in  1  downstream accepts; the legacy stall maps to out_ready = !stall.
out_data  out  DATA_W  data of stage DEPTH-1.
out_ctrl  out  CTRL_W  control of stage DEPTH-1.
stage_valid  out  DEPTH  valid bits of all stages, for hazard/forwarding logic.
occupancy  out  $clog2(DEPTH+1)  registered count of valid stages.

Behaviour:
- Reset (rst_n low, asynchronous): all valid=0, ctrl=0, data=0, occupancy=0; out_valid=0, out_ctrl=0, out_data=0. in_ready follows the combinational rule below and is therefore 1 whenever out_ready=1 or the chain is empty.
- Stage order: 0 = input, DEPTH-1 = output. Latency is DEPTH edges when there is no backpressure; throughput is 1 item per edge.
- COLLAPSE=1:
  - mv[DEPTH-1] = valid[DEPTH-1] & out_ready.
  - mv[i] = valid[i] & (!valid[i+1] | mv[i+1]).
  - in_ready = !valid[0] | mv[0].
  - Stage i loads from i-1 (or from the input) when its source moves; otherwise it holds if it did not move, or becomes invalid if it did.
- COLLAPSE=0:
  - adv = out_ready | !valid[DEPTH-1]; in_ready = adv.
  - On adv, all stages shift together, and a bubble enters stage 0 when in_valid=0. When adv=0, all stages hold.
- Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Flush:
  - flush_mask[i]=1 forces next valid[i]=0 and ctrl[i]=0. data[i] is zeroed only when FLUSH_DATA=1.
  - Flush has priority over a simultaneous load into stage i, so the arriving item is discarded.
  - An input transfer coinciding with flush_mask[0] completes the handshake (in_ready unaffected) and the item is dropped.
  - flush_mask does not gate in_ready or out_valid combinationally. An output transfer in the same cycle as flush_mask[DEPTH-1] still counts as delivered.
- Invalid stages: ctrl is 0 after reset or flush. A stage vacated by a move keeps stale ctrl/data, but downstream must qualify on valid.
- occupancy: registered.
  - next = occ + in_xfer_kept - out_xfer - number of valid stages killed by flush_mask. Only items that are valid and not simultaneously moving out are counted as killed.
  - Must always equal popcount(stage_valid); this is a bench assertion.
  - Never exceeds DEPTH and never underflows.
- DEPTH=1 with out_ready=!stall and flush_mask=flush reproduces the existing single-register stage.
- Reset mid-stream: all items lost immediately. The first post-reset edge with in_valid=1 loads stage 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the ctrl field layout constants (REGWRITE_BIT, MEMREAD_BIT, RD_LSB/RD_W, BYTE_EN_LSB/BYTE_EN_W) and CTRL_W_DEFAULT;
  - a function clog2.
- One sub-module, pipe_stage_slot: a single register slot with load/hold/kill inputs. It is instantiated DEPTH times inside a generate loop; the advance logic and occupancy counter live in the top level.

Test Plan:
1. Reset then stream: DEPTH=2, COLLAPSE=1, in_valid=1, in_data=1,2,3..., out_ready=1 -> first out_valid on edge 2 with out_data=1, then one item per edge; occupancy=2 steady.
2. Backpressure collapse: DEPTH=3, items A, B, gap, C; out_ready=0 for 4 edges -> stage_valid=111 and in_ready=0; on out_ready=1, outputs A, B, C on consecutive edges.
3. Lockstep: COLLAPSE=0, same stimulus -> the gap persists as a bubble at the output; with out_ready=0 and valid[2]=1, nothing moves and in_ready=0.
4. Flush: 3 valid items, flush_mask=3'b011 -> next stage_valid=100, ctrl of stages 0 and 1 = 0, occupancy 3->1; FLUSH_DATA=0 leaves data intact.
5. Flush coinciding with accept: in_valid=1, in_ready=1, flush_mask[0]=1 -> handshake completes, stage 0 invalid, occupancy unchanged by the input.
6. Async reset mid-stream: assert rst_n=0 between clock edges with occupancy=2 -> out_valid, out_ctrl and occupancy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-field layout and helpers shared by the pipeline register chain
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 8;
    localparam int REGWRITE_BIT   = 7;
    localparam int MEMREAD_BIT    = 6;
    localparam int RD_LSB         = 2;
    localparam int RD_W           = 4;
    localparam int BYTE_EN_LSB    = 0;
    localparam int BYTE_EN_W      = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one pipeline register holding a valid bit, data and control
module pipe_stage_slot #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 8,
    parameter bit FLUSH_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              hold,
    input  logic              kill,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // kill beats load; a slot that neither loads nor holds is vacated but keeps stale payload
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (FLUSH_DATA) data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep valid/ready pipeline register chain with flush and occupancy
module pipe_stage_chain import pipe_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = CTRL_W_DEFAULT,
    parameter int DEPTH      = 2,
    parameter bit COLLAPSE   = 1'b1,
    parameter bit FLUSH_DATA = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [DEPTH-1:0]            flush_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [DEPTH-1:0]            stage_valid,
    output logic [clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = clog2(DEPTH + 1);

    logic [DEPTH-1:0]             v;
    logic [DEPTH-1:0]             mv;
    logic [DEPTH-1:0]             nv;
    logic [DEPTH:0]               src_mv;
    logic [DEPTH:0][DATA_W-1:0]   d_chain;
    logic [DEPTH:0][CTRL_W-1:0]   c_chain;
    logic                         adv;
    logic                         m;
    logic                         in_xfer;
    logic [OCC_W-1:0]             cnt;

    // per-stage move decisions, resolved from the output end back toward the input
    always_comb begin
        adv = out_ready | !v[DEPTH-1];
        m = v[DEPTH-1] & out_ready;
        mv = '0;
        mv[DEPTH-1] = m;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            m = COLLAPSE ? v[i] & (!v[i+1] | m) : v[i] & adv;
            mv[i] = m;
        end
        in_ready = COLLAPSE ? !v[0] | mv[0] : adv;
    end

    assign in_xfer = in_valid & in_ready;
    // bit 0 is the input transfer, bit i+1 is stage i moving on
    assign src_mv  = {mv, in_xfer};

    // next-state valid vector and its population count feed the occupancy register
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nv[i] = !flush_mask[i] & (src_mv[i] | (v[i] & !src_mv[i+1]));
            cnt = cnt + OCC_W'(nv[i]);
        end
    end

    // occupancy is registered alongside the slots so it always matches stage_valid
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) occupancy <= '0;
        else occupancy <= cnt;
    end

    assign d_chain[0] = in_data;
    assign c_chain[0] = in_ctrl;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_stage_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .FLUSH_DATA (FLUSH_DATA)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (src_mv[g]),
            .hold      (!src_mv[g+1]),
            .kill      (flush_mask[g]),
            .load_data (d_chain[g]),
            .load_ctrl (c_chain[g]),
            .valid     (v[g]),
            .data      (d_chain[g+1]),
            .ctrl      (c_chain[g+1])
        );
    end

    assign stage_valid = v;
    assign out_valid   = v[DEPTH-1];
    assign out_data    = d_chain[DEPTH];
    assign out_ctrl    = c_chain[DEPTH];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: three chain configurations driven in parallel against an item-level model
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic [2:0]  flush = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [7:0]  oc0, oc1, oc2;
    logic [1:0]  sv0;
    logic [2:0]  sv1, sv2;
    logic [1:0]  occ0, occ1, occ2;

    always #5 clk = ~clk;

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .COLLAPSE(1'b1), .FLUSH_DATA(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush_mask(flush[1:0]), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .stage_valid(sv0), .occupancy(occ0));

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .COLLAPSE(1'b1), .FLUSH_DATA(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush_mask(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .stage_valid(sv1), .occupancy(occ1));

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .COLLAPSE(1'b0), .FLUSH_DATA(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush_mask(flush), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_ctrl(oc2), .stage_valid(sv2), .occupancy(occ2));

    // model: per instance, a row of item slots (valid, data, ctrl)
    bit   [7:0]  mvld [3];
    logic [31:0] mdat [3][8];
    logic [7:0]  mctl [3][8];

    function automatic int depth_of(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic bit col_of(int k);
        return k != 2;
    endfunction

    function automatic bit fd_of(int k);
        return k == 2;
    endfunction

    function automatic logic [7:0] ctrl_of(logic [31:0] d);
        logic [7:0] c;
        c = '0;
        c[REGWRITE_BIT] = 1'b1;
        c[MEMREAD_BIT] = d[0];
        c[RD_LSB +: RD_W] = d[RD_W:1];
        c[BYTE_EN_LSB +: BYTE_EN_W] = d[BYTE_EN_W-1:0];
        return c;
    endfunction

    // sweep items toward the output one place each, top first, into any slot left free
    function automatic bit [7:0] squeeze(bit [7:0] vv, int dd, bit ordy);
        for (int i = dd - 1; i >= 0; i--) begin
            if (vv[i]) begin
                if (i == dd - 1) begin
                    if (ordy) vv[i] = 1'b0;
                end else if (!vv[i+1]) begin
                    vv[i+1] = 1'b1;
                    vv[i] = 1'b0;
                end
            end
        end
        return vv;
    endfunction

    function automatic bit model_ready(int k, bit ordy);
        bit [7:0] t;
        if (!col_of(k)) return ordy | !mvld[k][depth_of(k)-1];
        t = squeeze(mvld[k], depth_of(k), ordy);
        return !t[0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mvld[k] = '0;
            for (int i = 0; i < 8; i++) begin
                mdat[k][i] = '0;
                mctl[k][i] = '0;
            end
        end
    endtask

    task automatic model_step(int k);
        int dd;
        bit ir;
        dd = depth_of(k);
        ir = model_ready(k, out_ready);
        if (col_of(k)) begin
            for (int i = dd - 1; i >= 0; i--) begin
                if (mvld[k][i]) begin
                    if (i == dd - 1) begin
                        if (out_ready) mvld[k][i] = 1'b0;
                    end else if (!mvld[k][i+1]) begin
                        mvld[k][i+1] = 1'b1;
                        mvld[k][i] = 1'b0;
                        mdat[k][i+1] = mdat[k][i];
                        mctl[k][i+1] = mctl[k][i];
                    end
                end
            end
            if (ir && in_valid) begin
                mvld[k][0] = 1'b1;
                mdat[k][0] = in_data;
                mctl[k][0] = in_ctrl;
            end
        end else if (ir) begin
            for (int i = dd - 1; i > 0; i--) begin
                mvld[k][i] = mvld[k][i-1];
                mdat[k][i] = mdat[k][i-1];
                mctl[k][i] = mctl[k][i-1];
            end
            mvld[k][0] = in_valid;
            mdat[k][0] = in_data;
            mctl[k][0] = in_ctrl;
        end
        for (int i = 0; i < dd; i++) begin
            if (flush[i]) begin
                mvld[k][i] = 1'b0;
                mctl[k][i] = '0;
                if (fd_of(k)) mdat[k][i] = '0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(int k, logic rdy, logic ov, logic [31:0] od, logic [7:0] oc,
                            logic [7:0] sv, logic [7:0] occ);
        int dd;
        dd = depth_of(k);
        chk($sformatf("u%0d in_ready", k), 32'(rdy), 32'(model_ready(k, out_ready)));
        chk($sformatf("u%0d out_valid", k), 32'(ov), 32'(mvld[k][dd-1]));
        chk($sformatf("u%0d stage_valid", k), 32'(sv), 32'(mvld[k]));
        chk($sformatf("u%0d occupancy", k), 32'(occ), 32'($countones(mvld[k])));
        chk($sformatf("u%0d occ_vs_popcount", k), 32'(occ), 32'($countones(sv)));
        if (mvld[k][dd-1]) begin
            chk($sformatf("u%0d out_data", k), od, mdat[k][dd-1]);
            chk($sformatf("u%0d out_ctrl", k), 32'(oc), 32'(mctl[k][dd-1]));
        end
    endtask

    initial model_reset();

    // state advances on the falling edge, in step with the chains
    always @(negedge clk) begin
        if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
    end

    // outputs are compared just after the rising edge, midway between state updates
    always @(posedge clk) begin
        #1;
        cmp_inst(0, rdy0, ov0, od0, oc0, 8'(sv0), 8'(occ0));
        cmp_inst(1, rdy1, ov1, od1, oc1, 8'(sv1), 8'(occ1));
        cmp_inst(2, rdy2, ov2, od2, oc2, 8'(sv2), 8'(occ2));
    end

    task automatic cyc(bit iv, logic [31:0] d, bit ordy, logic [2:0] fl);
        @(posedge clk);
        in_valid = iv;
        in_data = d;
        in_ctrl = ctrl_of(d);
        out_ready = ordy;
        flush = fl;
        #1;
    endtask

    initial begin
        cyc(0, 0, 1, 0);
        chk("reset u0 out_valid", 32'(ov0), 0);
        chk("reset u0 out_data", od0, 0);
        chk("reset u0 out_ctrl", 32'(oc0), 0);
        chk("reset u1 occupancy", 32'(occ1), 0);
        chk("reset u2 in_ready", 32'(rdy2), 1);
        cyc(0, 0, 1, 0);
        rst_n = 1'b1;

        cyc(1, 1, 1, 0);
        chk("stream W1 u0 stage_valid", 32'(sv0), 0);
        cyc(1, 2, 1, 0);
        cyc(1, 3, 1, 0);
        chk("stream first out_valid u0", 32'(ov0), 1);
        chk("stream first out_data u0", od0, 1);
        cyc(1, 4, 1, 0);
        chk("stream u0 out_data 2", od0, 2);
        chk("stream u0 occupancy", 32'(occ0), 2);
        chk("stream u1 out_data 1", od1, 1);
        chk("stream u1 occupancy", 32'(occ1), 3);
        cyc(1, 5, 1, 0);
        chk("stream u0 out_data 3", od0, 3);
        chk("stream u2 out_data 2", od2, 2);
        repeat (3) cyc(0, 0, 1, 0);

        cyc(1, 'hA, 0, 0);
        cyc(1, 'hB, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 'hC, 0, 0);
        chk("bp u2 blocked in_ready", 32'(rdy2), 0);
        chk("bp u1 open in_ready", 32'(rdy1), 1);
        cyc(0, 0, 0, 0);
        chk("bp u1 stage_valid full", 32'(sv1), 32'b111);
        chk("bp u1 in_ready", 32'(rdy1), 0);
        chk("bp u2 stage_valid", 32'(sv2), 32'b110);
        cyc(0, 0, 1, 0);
        chk("bp u1 out A", od1, 'hA);
        cyc(0, 0, 1, 0);
        chk("bp u1 out B", od1, 'hB);
        cyc(0, 0, 1, 0);
        chk("bp u1 out C", od1, 'hC);
        chk("bp u1 out_valid C", 32'(ov1), 1);
        cyc(0, 0, 1, 0);

        cyc(1, 'hA, 1, 0);
        cyc(1, 'hB, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 'hC, 1, 0);
        chk("lock u2 out A", od2, 'hA);
        cyc(0, 0, 1, 0);
        chk("lock u2 out B", od2, 'hB);
        cyc(0, 0, 1, 0);
        chk("lock u2 bubble", 32'(ov2), 0);
        cyc(0, 0, 1, 0);
        chk("lock u2 out_valid C", 32'(ov2), 1);
        chk("lock u2 out C", od2, 'hC);
        cyc(0, 0, 1, 0);

        cyc(1, 'h11, 0, 0);
        cyc(1, 'h22, 0, 0);
        cyc(1, 'h33, 0, 0);
        cyc(0, 0, 0, 3'b011);
        chk("flush pre u1 occupancy", 32'(occ1), 3);
        chk("flush pre u1 stage_valid", 32'(sv1), 32'b111);
        cyc(0, 0, 0, 3'b100);
        chk("flush u1 stage_valid", 32'(sv1), 32'b100);
        chk("flush u1 occupancy", 32'(occ1), 1);
        chk("flush u1 out_data", od1, 'h11);
        chk("flush u1 out_ctrl", 32'(oc1), 32'(ctrl_of('h11)));
        chk("flush u0 occupancy", 32'(occ0), 0);
        chk("flush u2 stage_valid", 32'(sv2), 32'b100);
        cyc(0, 0, 1, 0);
        chk("flush out u1 out_valid", 32'(ov1), 0);
        chk("flush keep u1 out_data", od1, 'h11);
        chk("flush u1 out_ctrl zero", 32'(oc1), 0);
        chk("flush zero u2 out_data", od2, 0);
        chk("flush u2 out_ctrl zero", 32'(oc2), 0);

        cyc(1, 'h55, 1, 3'b001);
        chk("flush accept u1 in_ready", 32'(rdy1), 1);
        cyc(0, 0, 1, 0);
        chk("flush accept u1 stage_valid", 32'(sv1), 0);
        chk("flush accept u1 occupancy", 32'(occ1), 0);
        chk("flush accept u0 occupancy", 32'(occ0), 0);

        cyc(1, 1, 1, 0);
        cyc(1, 2, 1, 0);
        cyc(0, 0, 0, 0);
        chk("arst pre u0 occupancy", 32'(occ0), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst u0 out_valid", 32'(ov0), 0);
        chk("arst u0 out_ctrl", 32'(oc0), 0);
        chk("arst u0 occupancy", 32'(occ0), 0);
        chk("arst u1 occupancy", 32'(occ1), 0);
        cyc(0, 0, 1, 0);
        cyc(1, 'h77, 1, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 0);
        chk("post reset u0 stage_valid", 32'(sv0), 32'b01);
        chk("post reset u1 stage_valid", 32'(sv1), 32'b001);

        for (int i = 0; i < 60; i++)
            cyc(i % 5 != 2, 32'h100 + i, (i % 4 != 0) && (i % 9 != 7),
                (i % 7 == 3) ? 3'b010 : ((i % 11 == 5) ? 3'b101 : 3'b000));
        repeat (4) cyc(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
